alu_sequencer: RTL and testbench

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/cpu_pkg.sv | 36 +++
 rtl/alu_sequencer_zreg64.sv | 29 ++
 rtl/alu_sequencer.sv | 139 +++++++++++++
 tb/tb_alu_sequencer.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg -- constants shared by the ALU sequencer and the external ALU.
//
// Contents:
//   DATA_W          operand / writeback word width
//   opcode_t        5-bit ALU opcode type, plus the opcode constants
//   state_t         sequencer state type, plus the state encodings
//   op_skips_exec() true for opcodes that finish in LOAD_B without an ALU pass
package cpu_pkg;

    localparam int DATA_W = 32;

    typedef logic [4:0] opcode_t;
    typedef logic [2:0] state_t;

    // Opcode constants; the ALU decodes the same values.
    localparam opcode_t OP_ADD  = 5'b00011;
    localparam opcode_t OP_MUL  = 5'b01111;
    localparam opcode_t OP_DIV  = 5'b10000;
    localparam opcode_t OP_NEG  = 5'b10001;
    localparam opcode_t OP_NOT  = 5'b10010;
    localparam opcode_t OP_NOP  = 5'b11010;
    localparam opcode_t OP_HALT = 5'b11011;

    // Sequencer state encodings.
    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_LOAD_B = 3'd1;
    localparam state_t ST_EXEC   = 3'd2;
    localparam state_t ST_WB_LO  = 3'd3;
    localparam state_t ST_WB_HI  = 3'd4;

    // nop and halt produce no result, so they never reach EXEC.
    function automatic logic op_skips_exec(input opcode_t op);
        return (op == OP_NOP) || (op == OP_HALT);
    endfunction

endpackage

// File: rtl/alu_sequencer_zreg64.sv
// zreg64 -- 64-bit result holding register for the ALU sequencer.
//
// Ports:
//   clock  in   rising-edge clock
//   clear  in   asynchronous active-low reset, zeroes q
//   load   in   capture d at the next rising edge
//   d      in   64-bit data to capture
//   q      out  64-bit held value
module zreg64 (
    input  logic        clock,
    input  logic        clear,
    input  logic        load,
    input  logic [63:0] d,
    output logic [63:0] q
);

    logic [63:0] z_q;

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            z_q <= '0;
        end else if (load) begin
            z_q <= d;
        end
    end

    assign q = z_q;

endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer -- drives an external ALU through a fixed operand/execute/
// writeback sequence: IDLE -> LOAD_B -> EXEC -> WB_LO [-> WB_HI] -> IDLE.
//
// Build option:
//   ALU_SEQUENCER_HILO_EN  when defined, Multiplication and Division write
//                          back both halves of the 64-bit result (WB_LO then
//                          WB_HI); otherwise every opcode writes back only
//                          the low word.
//
// Ports:
//   clock         in   rising-edge clock
//   clear         in   asynchronous active-low reset
//   start         in   operation request, sampled only in IDLE
//   opcode[4:0]   in   ALU opcode, sampled with start
//   bus_in[31:0]  in   operand bus: operand A with start, operand B next cycle
//   alu_c[63:0]   in   combinational ALU result
//   alu_y[31:0]   out  latched operand A to the ALU
//   alu_b[31:0]   out  latched operand B to the ALU
//   alu_op[4:0]   out  latched opcode to the ALU
//   busy          out  high in every state except IDLE
//   result[31:0]  out  writeback word, zero when result_valid is low
//   result_valid  out  result carries a writeback word this cycle
//   result_hi     out  current writeback word is the upper half of Z
//   done          out  one-cycle pulse on the final cycle of an operation
module alu_sequencer
    import cpu_pkg::*;
(
    input  logic                clock,
    input  logic                clear,
    input  logic                start,
    input  logic [4:0]          opcode,
    input  logic [DATA_W-1:0]   bus_in,
    input  logic [2*DATA_W-1:0] alu_c,
    output logic [DATA_W-1:0]   alu_y,
    output logic [DATA_W-1:0]   alu_b,
    output logic [4:0]          alu_op,
    output logic                busy,
    output logic [DATA_W-1:0]   result,
    output logic                result_valid,
    output logic                result_hi,
    output logic                done
);

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   y_q, y_d;
    logic [DATA_W-1:0]   b_q, b_d;
    opcode_t             op_q, op_d;
    logic [2*DATA_W-1:0] z_q;
    logic                z_load;
    logic                two_word;

`ifdef ALU_SEQUENCER_HILO_EN
    assign two_word = (op_q == OP_MUL) || (op_q == OP_DIV);
`else
    assign two_word = 1'b0;
`endif

    // Next-state and operand-latch logic.  The operand registers only change
    // on acceptance (Y, OP) and in LOAD_B (B), so the ALU inputs stay frozen
    // from EXEC until the sequence is back in IDLE.
    always_comb begin
        state_d = state_q;
        y_d     = y_q;
        b_d     = b_q;
        op_d    = op_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    y_d     = bus_in;
                    op_d    = opcode;
                    state_d = ST_LOAD_B;
                end
            end
            ST_LOAD_B: begin
                b_d     = bus_in;
                state_d = op_skips_exec(op_q) ? ST_IDLE : ST_EXEC;
            end
            ST_EXEC:  state_d = ST_WB_LO;
            ST_WB_LO: state_d = two_word ? ST_WB_HI : ST_IDLE;
            ST_WB_HI: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q <= ST_IDLE;
            y_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
            b_q     <= b_d;
            op_q    <= op_d;
        end
    end

    // Z captures the ALU output at the edge that closes EXEC.
    assign z_load = (state_q == ST_EXEC);

    zreg64 u_zreg (
        .clock (clock),
        .clear (clear),
        .load  (z_load),
        .d     (alu_c),
        .q     (z_q)
    );

    // Outputs decode directly from the state, so an asynchronous clear
    // zeroes them in the same cycle.
    always_comb begin
        busy         = (state_q != ST_IDLE);
        result       = '0;
        result_valid = 1'b0;
        result_hi    = 1'b0;
        done         = 1'b0;
        case (state_q)
            ST_LOAD_B: done = op_skips_exec(op_q);
            ST_WB_LO: begin
                result       = z_q[DATA_W-1:0];
                result_valid = 1'b1;
                done         = !two_word;
            end
            ST_WB_HI: begin
                result       = z_q[2*DATA_W-1:DATA_W];
                result_valid = 1'b1;
                result_hi    = 1'b1;
                done         = 1'b1;
            end
            default: ;
        endcase
    end

    assign alu_y  = y_q;
    assign alu_b  = b_q;
    assign alu_op = op_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer -- scoreboard bench for alu_sequencer.  The stimulus
// process pushes expected writebacks (value, half, done, cycle) when an
// operation is accepted; an independent monitor pops and compares whenever
// the DUT shows result_valid or done.  A small behavioural ALU sits on the
// alu_* ports.  Works with or without ALU_SEQUENCER_HILO_EN.
module tb_alu_sequencer;
    import cpu_pkg::*;

    logic        clock = 1'b0;
    logic        clear;
    logic        start;
    logic [4:0]  opcode;
    logic [31:0] bus_in;
    logic [63:0] alu_c;
    logic [31:0] alu_y, alu_b, result;
    logic [4:0]  alu_op;
    logic        busy, result_valid, result_hi, done;

    always #5 clock = ~clock;

    alu_sequencer dut (
        .clock        (clock),
        .clear        (clear),
        .start        (start),
        .opcode       (opcode),
        .bus_in       (bus_in),
        .alu_c        (alu_c),
        .alu_y        (alu_y),
        .alu_b        (alu_b),
        .alu_op       (alu_op),
        .busy         (busy),
        .result       (result),
        .result_valid (result_valid),
        .result_hi    (result_hi),
        .done         (done)
    );

    // External ALU model.  Division packs remainder high, quotient low.
    logic [31:0] neg_b;
    always_comb begin
        neg_b = 32'd0 - alu_b;
        alu_c = 64'd0;
        case (alu_op)
            OP_ADD: alu_c = {32'd0, alu_y + alu_b};
            OP_MUL: alu_c = {32'd0, alu_y} * {32'd0, alu_b};
            OP_DIV: alu_c = (alu_b != 0) ? {alu_y % alu_b, alu_y / alu_b} : 64'd0;
            OP_NEG: alu_c = {{32{neg_b[31]}}, neg_b};
            OP_NOT: alu_c = {32'd0, ~alu_b};
            default: alu_c = 64'd0;
        endcase
    end

    typedef struct {
        logic        valid;
        logic        hi;
        logic [31:0] res;
        logic        dn;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   done_cnt = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every valid word or done pulse must match the head of the queue.
    always @(negedge clock) begin
        exp_t e;
        if (done) done_cnt++;
        if (clear && (result_valid || done)) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_output: result=0x%0h valid=%0b hi=%0b done=%0b, expected no output (cycle %0d)",
                         result, result_valid, result_hi, done, cyc);
            end else begin
                e = sb.pop_front();
                check("wb_cycle", 64'(cyc), 64'(e.cyc));
                check("wb_valid", 64'(result_valid), 64'(e.valid));
                check("wb_hi", 64'(result_hi), 64'(e.hi));
                check("wb_result", 64'(result), 64'(e.res));
                check("wb_done", 64'(done), 64'(e.dn));
            end
        end
    end

    function automatic int words_for(input logic [4:0] op);
        if (op == OP_NOP || op == OP_HALT) return 0;
`ifdef ALU_SEQUENCER_HILO_EN
        if (op == OP_MUL || op == OP_DIV) return 2;
`endif
        return 1;
    endfunction

    task automatic push(input logic v, input logic h, input logic [31:0] r, input logic d, input int c);
        exp_t e;
        e.valid = v; e.hi = h; e.res = r; e.dn = d; e.cyc = c;
        sb.push_back(e);
    endtask

    // Call at a negedge with the DUT idle.  Returns just after the accepting
    // edge with operand B on the bus.  expect_out=0 pushes nothing.
    task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] z, input bit expect_out, output int acc);
        int w;
        start = 1'b1; opcode = op; bus_in = a;
        @(posedge clock); #1;
        acc = cyc;
        start = 1'b0; bus_in = b;
        check("accept_busy", 64'(busy), 64'd1);
        w = words_for(op);
        if (expect_out) begin
            if (w == 0) begin
                push(1'b0, 1'b0, 32'd0, 1'b1, acc);
            end else if (w == 1) begin
                push(1'b1, 1'b0, z[31:0], 1'b1, acc + 2);
            end else begin
                push(1'b1, 1'b0, z[31:0], 1'b0, acc + 2);
                push(1'b1, 1'b1, z[63:32], 1'b1, acc + 3);
            end
        end
    endtask

    task automatic wait_idle(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s_timeout: busy=%0b, required 0 within 12 cycles", name, busy);
        end
    endtask

    task automatic run_op(input string name, input logic [4:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] z);
        int acc;
        issue(op, a, b, z, 1'b1, acc);
        wait_idle(name);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_result"}, 64'(result), 64'd0);
        check({tag, "_valid"}, 64'(result_valid), 64'd0);
        check({tag, "_hi"}, 64'(result_hi), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_alu_y"}, 64'(alu_y), 64'd0);
        check({tag, "_alu_b"}, 64'(alu_b), 64'd0);
        check({tag, "_alu_op"}, 64'(alu_op), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int d0;
        clear = 1'b1; start = 1'b0; opcode = 5'd0; bus_in = 32'd0;
        #2 clear = 1'b0;
        repeat (2) @(negedge clock);
        check_outputs_zero("reset");
        clear = 1'b1;

        // Addition straight after reset release; busy timing checked by hand.
        issue(OP_ADD, 32'd5, 32'd3, 64'd8, 1'b1, acc);
        repeat (3) @(negedge clock);
        check("add_busy_wb_lo", 64'(busy), 64'd1);
        @(negedge clock);
        check("add_busy_after", 64'(busy), 64'd0);

        // Multiplication: 0x10000 * 0x10000 = 0x1_00000000.
        run_op("mul", OP_MUL, 32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000);
        // Division: 100 / 7 = 14 remainder 2.
        run_op("div", OP_DIV, 32'd100, 32'd7, 64'h0000_0002_0000_000E);
        // Unary ops: A is ignored by the ALU.
        run_op("neg", OP_NEG, 32'd99, 32'd5, 64'hFFFF_FFFF_FFFF_FFFB);

        // start pulsed during EXEC with another opcode is dropped.
        issue(OP_ADD, 32'd10, 32'd20, 64'd30, 1'b1, acc);
        d0 = done_cnt;
        @(negedge clock);
        @(negedge clock);
        start = 1'b1; opcode = OP_NOT; bus_in = 32'hDEAD_BEEF;
        @(negedge clock);
        start = 1'b0; opcode = 5'd0; bus_in = 32'd0;
        wait_idle("exec_start");
        repeat (3) @(negedge clock);
        check("exec_start_busy", 64'(busy), 64'd0);
        check("exec_start_alu_op", 64'(alu_op), 64'(OP_ADD));
        check("exec_start_alu_y", 64'(alu_y), 64'd10);
        check("exec_start_alu_b", 64'(alu_b), 64'd20);
        #1;
        check("exec_start_done_pulses", 64'(done_cnt - d0), 64'd1);

        // start held during the done cycle is ignored, accepted one cycle later.
        @(negedge clock);
        issue(OP_ADD, 32'd1, 32'd2, 64'd3, 1'b1, acc);
        @(negedge clock);
        @(negedge clock);
        @(negedge clock);
        start = 1'b1; opcode = OP_ADD; bus_in = 32'd7;
        @(negedge clock);
        check("done_start_ignored", 64'(busy), 64'd0);
        issue(OP_ADD, 32'd7, 32'd8, 64'd15, 1'b1, acc);
        wait_idle("after_done_start");

        // Asynchronous clear in EXEC: immediate zero outputs, no writeback.
        issue(OP_ADD, 32'd5, 32'd6, 64'd11, 1'b0, acc);
        @(negedge clock);
        @(negedge clock);
        clear = 1'b0;
        #1;
        check_outputs_zero("clear_exec");
        @(negedge clock);
        clear = 1'b1;
        #1;
        check("clear_release_idle", 64'(busy), 64'd0);
        repeat (4) @(negedge clock);

        // NOT leaves Z = 0x00000000_F0F0F0F0; nop and halt must not touch it.
        run_op("not", OP_NOT, 32'd0, 32'h0F0F_0F0F, 64'h0000_0000_F0F0_F0F0);
        run_op("nop", OP_NOP, 32'd11, 32'd22, 64'd0);
        check("nop_z_unchanged", dut.u_zreg.q, 64'h0000_0000_F0F0_F0F0);
        run_op("halt", OP_HALT, 32'd33, 32'd44, 64'd0);
        check("halt_z_unchanged", dut.u_zreg.q, 64'h0000_0000_F0F0_F0F0);

        repeat (3) @(negedge clock);
        check("scoreboard_empty", 64'(sb.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
